// File: rtl/stopwatch_timebase_if.sv
// Stopwatch time base bundle: button pulses in, counter/strobe outputs back.
// MINUTES_EN adds the minutes count to the bundle.
interface stopwatch_timebase_if;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] tenth_sec;
    logic [5:0] sec;
`ifdef MINUTES_EN
    logic [5:0] min;
`endif
    logic       running;
    logic       lap_en;

    modport master (
        output start_stop, clear, lap,
`ifdef MINUTES_EN
        input  min,
`endif
        input  tenth_sec, sec, running, lap_en
    );

    modport slave (
        input  start_stop, clear, lap,
`ifdef MINUTES_EN
        output min,
`endif
        output tenth_sec, sec, running, lap_en
    );
endinterface

// File: rtl/stopwatch_timebase.sv
// Stopwatch time base: 0.1 s prescaler, tenths/seconds counters and run/pause/clear FSM.
// Define MINUTES_EN to add a minutes counter fed by the seconds carry.
module stopwatch_timebase #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 10
) (
    input logic                clk,
    input logic                rstn,
    stopwatch_timebase_if.slave bus
);
    localparam int unsigned   DIV       = CLK_HZ / TICK_HZ;
    localparam int unsigned   PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StPause = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    tenth_q, tenth_d;
    logic [5:0]    sec_q, sec_d;
`ifdef MINUTES_EN
    logic [5:0]    min_q, min_d;
`endif
    logic          running_q, lap_en_q;
    logic          tick, zero;

    // start_stop outranks clear; clear only acts from PAUSE
    always_comb begin
        state_d = state_q;
        zero    = 1'b0;
        unique case (state_q)
            StIdle:  if (bus.start_stop) state_d = StRun;
            StRun:   if (bus.start_stop) state_d = StPause;
            StPause: begin
                if (bus.start_stop) begin
                    state_d = StRun;
                end else if (bus.clear) begin
                    state_d = StIdle;
                    zero    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign tick = (state_q == StRun) && (presc_q == PRESC_MAX);

    always_comb begin
        presc_d = presc_q;
        tenth_d = tenth_q;
        sec_d   = sec_q;
`ifdef MINUTES_EN
        min_d   = min_q;
`endif
        if (zero) begin
            presc_d = '0;
            tenth_d = '0;
            sec_d   = '0;
`ifdef MINUTES_EN
            min_d   = '0;
`endif
        end else if (state_q == StRun) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                if (tenth_q == 4'd9) begin
                    tenth_d = '0;
                    if (sec_q == 6'd59) begin
                        sec_d = '0;
`ifdef MINUTES_EN
                        min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
`endif
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    tenth_d = tenth_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            tenth_q   <= '0;
            sec_q     <= '0;
`ifdef MINUTES_EN
            min_q     <= '0;
`endif
            running_q <= 1'b0;
            lap_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            tenth_q   <= tenth_d;
            sec_q     <= sec_d;
`ifdef MINUTES_EN
            min_q     <= min_d;
`endif
            running_q <= (state_d == StRun);
            lap_en_q  <= bus.lap && (state_q == StRun);
        end
    end

    assign bus.tenth_sec = tenth_q;
    assign bus.sec       = sec_q;
`ifdef MINUTES_EN
    assign bus.min       = min_q;
`endif
    assign bus.running   = running_q;
    assign bus.lap_en    = lap_en_q;
endmodule

// File: tb/tb_stopwatch_timebase.sv
// Scoreboard bench: an elapsed-run-clocks model predicts every cycle and every lap capture.
module tb_stopwatch_timebase;
    localparam int unsigned DIV = 10;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    stopwatch_timebase_if bus ();

    stopwatch_timebase #(
        .CLK_HZ  (100),
        .TICK_HZ (10)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [3:0] tenth;
        logic [5:0] sec;
        logic [5:0] min;
        logic       running;
        logic       lap_en;
    } exp_t;

    typedef struct {
        logic [3:0] tenth;
        logic [5:0] sec;
        logic [5:0] min;
    } cap_t;

    exp_t exp_q[$];
    cap_t lap_q[$];

    int checks = 0;
    int errors = 0;

    // Model: state 0 idle, 1 run, 2 pause; time is clocks spent in RUN since last clear
    int m_state = 0;
    int elapsed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step(input bit ss, input bit clr, input bit lp, input bit rst_n = 1'b1);
        exp_t e;
        cap_t c;
        int   t;
        bit   lap_hit;
        bus.start_stop = ss;
        bus.clear      = clr;
        bus.lap        = lp;
        rstn           = rst_n;
        @(posedge clk);
        #1;
        lap_hit = 1'b0;
        if (!rst_n) begin
            m_state = 0;
            elapsed = 0;
        end else begin
            lap_hit = lp && (m_state == 1);
            if (m_state == 1) elapsed++;
            case (m_state)
                0: if (ss) m_state = 1;
                1: if (ss) m_state = 2;
                default: begin
                    if (ss) m_state = 1;
                    else if (clr) begin
                        m_state = 0;
                        elapsed = 0;
                    end
                end
            endcase
        end
        t         = elapsed / DIV;
        e.tenth   = 4'(t % 10);
        e.sec     = 6'((t / 10) % 60);
        e.min     = 6'((t / 600) % 60);
        e.running = (m_state == 1);
        e.lap_en  = lap_hit;
        exp_q.push_back(e);
        if (lap_hit) begin
            c.tenth = e.tenth;
            c.sec   = e.sec;
            c.min   = e.min;
            lap_q.push_back(c);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: one expected record per cycle, plus a capture record per lap strobe
    initial begin
        exp_t e;
        cap_t c;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("tenth_sec", 32'(bus.tenth_sec), 32'(e.tenth));
                chk("sec", 32'(bus.sec), 32'(e.sec));
`ifdef MINUTES_EN
                chk("min", 32'(bus.min), 32'(e.min));
`endif
                chk("running", 32'(bus.running), 32'(e.running));
                chk("lap_en", 32'(bus.lap_en), 32'(e.lap_en));
                if (bus.lap_en === 1'b1) begin
                    if (lap_q.size() == 0) begin
                        chk("lap_unexpected", 32'(1), 32'(0));
                    end else begin
                        c = lap_q.pop_front();
                        chk("lap_cap_sec", 32'(bus.sec), 32'(c.sec));
                        chk("lap_cap_tenth", 32'(bus.tenth_sec), 32'(c.tenth));
`ifdef MINUTES_EN
                        chk("lap_cap_min", 32'(bus.min), 32'(c.min));
`endif
                    end
                end
            end
        end
    end

    initial begin
        bus.start_stop = 1'b0;
        bus.clear      = 1'b0;
        bus.lap        = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        idle(50);
        // clear and lap while idle do nothing
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        idle(100);
        // run through 59.9 -> 00.0 with sparse laps
        for (int i = 0; i < 6000; i++) step(1'b0, 1'b0, $urandom_range(0, 49) == 0);
        // pause, lap in pause, clear, restart, clear while running, ss+clear in pause
        step(1'b1, 1'b0, 1'b0);
        idle(40);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        idle(5);
        step(1'b1, 1'b0, 1'b0);
        idle(200);
        step(1'b0, 1'b1, 1'b0);
        idle(30);
        step(1'b1, 1'b0, 1'b1);
        idle(10);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        idle(20);
        // randomized mix, including rare mid-run resets
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 1999) != 0);
        end
        bus.start_stop = 1'b0;
        bus.clear      = 1'b0;
        bus.lap        = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'(0));
        chk("lap_q_drained", 32'(lap_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
